// File: rtl/vga_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ball_engine
//  Brief    : Single-clock VGA timing generator with pixel clock-enable
//             divider and a square ball renderer. The ball is steered by
//             buttons (manual) or bounces off the screen edges (bounce).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_ball_engine #(
   parameter int   CLK_DIV    = 2,
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   BALL_SIZE  = 8,
   parameter int   RGB_W      = 3,
   parameter logic [RGB_W-1:0] BALL_COLOR = 3'b111,
   parameter logic [RGB_W-1:0] BG_COLOR   = 3'b001,
   localparam int  c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  c_X_W      = $clog2(c_H_TOTAL),
   localparam int  c_Y_W      = $clog2(c_V_TOTAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   input  logic [2:0]       speed,
   output logic             h_sync,
   output logic             v_sync,
   output logic [RGB_W-1:0] rgb,
   output logic             active_area,
   output logic [c_X_W-1:0] coord_x,
   output logic [c_Y_W-1:0] coord_y,
   output logic             frame_tick
);

   localparam int c_XMAX     = H_ACTIVE - BALL_SIZE;
   localparam int c_YMAX     = V_ACTIVE - BALL_SIZE;
   localparam int c_HS_START = H_ACTIVE + H_FP;
   localparam int c_HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int c_VS_START = V_ACTIVE + V_FP;
   localparam int c_VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

   logic pe;

   // Pixel enable: divider counter, or a constant enable when CLK_DIV is 1
   generate
      if (CLK_DIV == 1) begin : g_div_bypass
         assign pe = 1'b1;
      end else begin : g_div
         localparam int c_DIV_W = $clog2(CLK_DIV);
         logic [c_DIV_W-1:0] div_q, div_d;

         // Next divider value, wrapping at CLK_DIV-1
         always_comb begin
            div_d = div_q + 1'b1;
            if (div_q == c_DIV_W'(CLK_DIV - 1)) begin
               div_d = '0;
            end
         end

         // Divider register
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               div_q <= '0;
            end else begin
               div_q <= div_d;
            end
         end

         assign pe = (div_q == c_DIV_W'(CLK_DIV - 1));
      end
   endgenerate

   logic [c_X_W-1:0] h_cnt_q, h_cnt_d;
   logic [c_Y_W-1:0] v_cnt_q, v_cnt_d;
   logic             h_last, v_last;

   assign h_last     = (h_cnt_q == c_X_W'(c_H_TOTAL - 1));
   assign v_last     = (v_cnt_q == c_Y_W'(c_V_TOTAL - 1));
   assign frame_tick = pe && h_last && v_last;

   // Raster counters advance once per pixel period
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pe) begin
         if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // Two-flop synchronisers for the buttons: {up, down, left, right}
   logic [3:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
   always_comb begin
      btn_meta_d = {up, down, left, right};
      btn_sync_d = btn_meta_q;
   end

   logic btn_up, btn_down, btn_left, btn_right;
   assign btn_up    = btn_sync_q[3];
   assign btn_down  = btn_sync_q[2];
   assign btn_left  = btn_sync_q[1];
   assign btn_right = btn_sync_q[0];

   // Ball state
   logic [c_X_W-1:0] bx_q, bx_d;
   logic [c_Y_W-1:0] by_q, by_d;
   logic             dx_q, dx_d, dy_q, dy_d;

   // One extra bit so a move past either edge is visible before clamping
   logic [c_X_W:0] x_inc, x_dec;
   logic [c_Y_W:0] y_inc, y_dec;
   logic           x_over, x_under, y_over, y_under;

   assign x_inc   = {1'b0, bx_q} + (c_X_W + 1)'(speed);
   assign x_dec   = {1'b0, bx_q} - (c_X_W + 1)'(speed);
   assign y_inc   = {1'b0, by_q} + (c_Y_W + 1)'(speed);
   assign y_dec   = {1'b0, by_q} - (c_Y_W + 1)'(speed);
   assign x_over  = (x_inc > (c_X_W + 1)'(c_XMAX));
   assign y_over  = (y_inc > (c_Y_W + 1)'(c_YMAX));
   assign x_under = x_dec[c_X_W];
   assign y_under = y_dec[c_Y_W];

   // Ball movement, evaluated only at the frame boundary
   always_comb begin
      bx_d = bx_q;
      by_d = by_q;
      dx_d = dx_q;
      dy_d = dy_q;
      if (frame_tick) begin
         if (mode) begin
            if (dx_q) begin
               if (x_over) begin
                  bx_d = c_X_W'(c_XMAX);
                  dx_d = 1'b0;
               end else begin
                  bx_d = x_inc[c_X_W-1:0];
               end
            end else if (x_under) begin
               bx_d = '0;
               dx_d = 1'b1;
            end else begin
               bx_d = x_dec[c_X_W-1:0];
            end
            if (dy_q) begin
               if (y_over) begin
                  by_d = c_Y_W'(c_YMAX);
                  dy_d = 1'b0;
               end else begin
                  by_d = y_inc[c_Y_W-1:0];
               end
            end else if (y_under) begin
               by_d = '0;
               dy_d = 1'b1;
            end else begin
               by_d = y_dec[c_Y_W-1:0];
            end
         end else begin
            if (btn_right && !btn_left) begin
               bx_d = x_over ? c_X_W'(c_XMAX) : x_inc[c_X_W-1:0];
            end else if (btn_left && !btn_right) begin
               bx_d = x_under ? '0 : x_dec[c_X_W-1:0];
            end
            if (btn_down && !btn_up) begin
               by_d = y_over ? c_Y_W'(c_YMAX) : y_inc[c_Y_W-1:0];
            end else if (btn_up && !btn_down) begin
               by_d = y_under ? '0 : y_dec[c_Y_W-1:0];
            end
         end
      end
   end

   // Pixel classification from the current counter state
   logic in_ball_x, in_ball_y, active, hs_win, vs_win;
   assign in_ball_x = (h_cnt_q >= bx_q) &&
                      ({1'b0, h_cnt_q} < ({1'b0, bx_q} + (c_X_W + 1)'(BALL_SIZE)));
   assign in_ball_y = (v_cnt_q >= by_q) &&
                      ({1'b0, v_cnt_q} < ({1'b0, by_q} + (c_Y_W + 1)'(BALL_SIZE)));
   assign active    = (h_cnt_q < c_X_W'(H_ACTIVE)) && (v_cnt_q < c_Y_W'(V_ACTIVE));
   assign hs_win    = (h_cnt_q >= c_X_W'(c_HS_START)) && (h_cnt_q <= c_X_W'(c_HS_END));
   assign vs_win    = (v_cnt_q >= c_Y_W'(c_VS_START)) && (v_cnt_q <= c_Y_W'(c_VS_END));

   logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d;
   logic             active_q, active_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic [c_X_W-1:0] coord_x_q, coord_x_d;
   logic [c_Y_W-1:0] coord_y_q, coord_y_d;

   // Video outputs are captured together on pe so they stay aligned
   always_comb begin
      h_sync_d  = h_sync_q;
      v_sync_d  = v_sync_q;
      active_d  = active_q;
      rgb_d     = rgb_q;
      coord_x_d = coord_x_q;
      coord_y_d = coord_y_q;
      if (pe) begin
         h_sync_d  = hs_win ? SYNC_POL : ~SYNC_POL;
         v_sync_d  = vs_win ? SYNC_POL : ~SYNC_POL;
         active_d  = active;
         coord_x_d = h_cnt_q;
         coord_y_d = v_cnt_q;
         if (!active) begin
            rgb_d = '0;
         end else if (in_ball_x && in_ball_y) begin
            rgb_d = BALL_COLOR;
         end else begin
            rgb_d = BG_COLOR;
         end
      end
   end

   // All state registers with asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         btn_meta_q <= '0;
         btn_sync_q <= '0;
         bx_q       <= c_X_W'(c_XMAX / 2);
         by_q       <= c_Y_W'(c_YMAX / 2);
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         h_sync_q   <= ~SYNC_POL;
         v_sync_q   <= ~SYNC_POL;
         active_q   <= 1'b0;
         rgb_q      <= '0;
         coord_x_q  <= '0;
         coord_y_q  <= '0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         btn_meta_q <= btn_meta_d;
         btn_sync_q <= btn_sync_d;
         bx_q       <= bx_d;
         by_q       <= by_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         h_sync_q   <= h_sync_d;
         v_sync_q   <= v_sync_d;
         active_q   <= active_d;
         rgb_q      <= rgb_d;
         coord_x_q  <= coord_x_d;
         coord_y_q  <= coord_y_d;
      end
   end

   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign active_area = active_q;
   assign rgb         = rgb_q;
   assign coord_x     = coord_x_q;
   assign coord_y     = coord_y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_ball_engine
//  Brief    : Self-checking bench for vga_ball_engine on a reduced raster
//             (24x17 pixel frame, 4-pixel ball, two clocks per pixel).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_ball_engine;

   localparam int CLK_DIV  = 2;
   localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int H_T      = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 24
   localparam int V_T      = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 17
   localparam int BALL     = 4;
   localparam int C_BALL   = 7;
   localparam int C_BG     = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mode = 1'b0;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic [2:0] speed = 3'd0;
   logic       h_sync, v_sync, active_area, frame_tick;
   logic [2:0] rgb;
   logic [4:0] coord_x, coord_y;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit mode;
      bit up, down, left, right;
      int speed;
      int ex, ey;
   } vec_t;

   vec_t vecs[21];

   always #5 clk = ~clk;

   vga_ball_engine #(
      .CLK_DIV(CLK_DIV),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(1'b0), .BALL_SIZE(BALL), .RGB_W(3),
      .BALL_COLOR(3'b111), .BG_COLOR(3'b001)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode),
      .up(up), .down(down), .left(left), .right(right), .speed(speed),
      .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb), .active_area(active_area),
      .coord_x(coord_x), .coord_y(coord_y), .frame_tick(frame_tick)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_h_sync"},     int'(h_sync),      1);
      check({tag, "_v_sync"},     int'(v_sync),      1);
      check({tag, "_rgb"},        int'(rgb),         0);
      check({tag, "_active"},     int'(active_area), 0);
      check({tag, "_coord_x"},    int'(coord_x),     0);
      check({tag, "_coord_y"},    int'(coord_y),     0);
      check({tag, "_frame_tick"}, int'(frame_tick),  0);
   endtask

   // Release reset on a falling edge and record when key events appear,
   // counting rising edges since release.
   task automatic run_after_release(input string tag);
      int hs_n, ft1, ft2, act1, act2, rgb2;
      hs_n = -1; ft1 = -1; ft2 = -1; act1 = -1; act2 = -1; rgb2 = -1;
      @(negedge clk);
      reset = 1'b1;
      for (int n = 1; n <= 1700; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) act1 = int'(active_area);
         if (n == 2) begin
            act2 = int'(active_area);
            rgb2 = int'(rgb);
         end
         if (hs_n < 0 && h_sync === 1'b0) hs_n = n;
         if (frame_tick === 1'b1) begin
            if (ft1 < 0) ft1 = n;
            else if (ft2 < 0) ft2 = n;
         end
      end
      check({tag, "_no_pe_clk1"},     act1, 0);
      check({tag, "_first_pe_clk2"},  act2, 1);
      check({tag, "_first_rgb_bg"},   rgb2, C_BG);
      check({tag, "_hsync_first_clk"}, hs_n, CLK_DIV + CLK_DIV * (H_ACTIVE + H_FP));
      check({tag, "_first_tick_clk"}, ft1, CLK_DIV * H_T * V_T - 1);
      check({tag, "_tick_period"},    ft2 - ft1, CLK_DIV * H_T * V_T);
   endtask

   task automatic wait_tick(input string tag);
      int seen;
      seen = 0;
      for (int n = 0; n < 2 * CLK_DIV * H_T * V_T && seen == 0; n++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) seen = 1;
      end
      check({tag, "_tick_seen"}, seen, 1);
   endtask

   // Called just after a frame_tick has been seen; checks every pixel of
   // all but the last line of the following frame against the expected ball.
   task automatic scan_frame(input string tag, input int ebx, input int eby);
      int fx, fy, nbad, bad_x, bad_y;
      fx = -1; fy = -1; nbad = 0; bad_x = -1; bad_y = -1;
      repeat (CLK_DIV + 1) @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < (V_T - 1) * H_T; p++) begin
         int  hx, vy;
         bit  act, inb;
         int  ergb, ehs, evs;
         hx   = p % H_T;
         vy   = p / H_T;
         act  = (hx < H_ACTIVE) && (vy < V_ACTIVE);
         inb  = (hx >= ebx) && (hx < ebx + BALL) && (vy >= eby) && (vy < eby + BALL);
         ergb = !act ? 0 : (inb ? C_BALL : C_BG);
         ehs  = (hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
         evs  = (vy >= V_ACTIVE + V_FP && vy < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
         if (fx < 0 && rgb === 3'(C_BALL)) begin
            fx = hx;
            fy = vy;
         end
         if (coord_x !== 5'(hx) || coord_y !== 5'(vy) || rgb !== 3'(ergb) ||
             active_area !== act || h_sync !== 1'(ehs) || v_sync !== 1'(evs)) begin
            if (nbad == 0) begin
               bad_x = hx;
               bad_y = vy;
            end
            nbad++;
         end
         if (p != (V_T - 1) * H_T - 1) repeat (CLK_DIV) @(negedge clk);
      end
      n_cmp++;
      if (fx != ebx || fy != eby) begin
         n_bad++;
         $display("FAIL %s_ball_pos: got (%0d,%0d), expected (%0d,%0d)", tag, fx, fy, ebx, eby);
      end
      n_cmp++;
      if (nbad != 0) begin
         n_bad++;
         $display("FAIL %s_pixels: %0d bad pixels (first at x=%0d y=%0d), expected 0",
                  tag, nbad, bad_x, bad_y);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          mode u d l r spd  x  y
      vecs[0]  = '{0, 0,0,0,0, 3,  6, 4};
      vecs[1]  = '{0, 0,0,0,1, 3,  9, 4};
      vecs[2]  = '{0, 0,0,0,1, 5, 12, 4};
      vecs[3]  = '{0, 1,1,1,0, 2, 10, 4};
      vecs[4]  = '{0, 0,1,0,0, 7, 10, 8};
      vecs[5]  = '{0, 1,0,1,1, 3, 10, 5};
      vecs[6]  = '{0, 0,0,1,0, 5,  5, 5};
      vecs[7]  = '{0, 0,0,1,0, 5,  0, 5};
      vecs[8]  = '{0, 0,0,1,0, 5,  0, 5};
      vecs[9]  = '{0, 1,0,0,0, 7,  0, 0};
      vecs[10] = '{1, 0,0,0,0, 0,  0, 0};
      vecs[11] = '{1, 0,0,0,0, 7,  7, 7};
      vecs[12] = '{1, 0,0,0,0, 7, 12, 8};
      vecs[13] = '{1, 0,0,0,0, 7,  5, 1};
      vecs[14] = '{1, 0,0,0,1, 7,  0, 0};
      vecs[15] = '{0, 0,1,0,1, 3,  3, 3};
      vecs[16] = '{1, 0,0,0,0, 4,  7, 7};
      vecs[17] = '{1, 0,0,0,0, 4, 11, 8};
      vecs[18] = '{1, 0,0,0,0, 1, 12, 7};
      vecs[19] = '{1, 0,0,0,0, 1, 12, 6};
      vecs[20] = '{1, 0,0,0,0, 2, 10, 4};

      // Power-up reset
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      run_after_release("rel1");

      // Directed frame-by-frame movement table
      for (int i = 0; i < 21; i++) begin
         string tag;
         tag   = $sformatf("vec%0d", i);
         mode  = vecs[i].mode;
         up    = vecs[i].up;
         down  = vecs[i].down;
         left  = vecs[i].left;
         right = vecs[i].right;
         speed = 3'(vecs[i].speed);
         wait_tick(tag);
         scan_frame(tag, vecs[i].ex, vecs[i].ey);
      end

      // Reset pulse in the middle of a frame, ball away from its home position
      mode = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; speed = 3'd0;
      wait_tick("pre_rst");
      repeat (10 * H_T * CLK_DIV + 7) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      run_after_release("rel2");
      wait_tick("post_rst");
      scan_frame("post_rst", 6, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
